// File: rtl/lane_deskew_pkg.sv
// Shared skew/deskew definitions: lane packing macro, skew convention, beat classes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// LANE(i) selects lane i of a packed LN*DW vector. It relies on a DW that is
// visible where the macro is expanded, so the skew side and the deskew side
// agree on packing without passing the width around.
`ifndef LANE_DESKEW_LANE_MACRO
`define LANE_DESKEW_LANE_MACRO
`define LANE(i) ((i)*DW) +: DW
`endif

package lane_deskew_pkg;

    // Skew convention shared with the upstream skew side: lane i lags by i cycles.
    localparam int SKEW_PER_LANE = 1;

    // The error counter is a fixed 8-bit saturating counter.
    localparam int         ERR_CNT_W   = 8;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Outcome of evaluating one aligned valid vector.
    typedef enum logic [1:0] {
        BEAT_NONE = 2'd0,   // no lane valid
        BEAT_FULL = 2'd1,   // every lane valid: emit an aligned beat
        BEAT_PART = 2'd2    // some but not all lanes valid: diagonal broken
    } beat_kind_t;

    // Skew applied upstream to a given lane.
    function automatic int lane_skew(input int lane);
        return lane * SKEW_PER_LANE;
    endfunction

    // Stages needed on a lane so that every lane sees the same total delay
    // as the most-skewed lane (ln-1).
    function automatic int deskew_depth(input int ln, input int lane);
        return lane_skew(ln - 1) - lane_skew(lane);
    endfunction

endpackage

// File: rtl/delay_chain.sv
// Fixed-length shift register of DN stages; each stage holds a DW-bit word.
// Latency: DN cycles from lane_dat to dly_dat.
// Backpressure: none; a word enters every cycle.
//
// Ports: clk, rst_n (async active-low), clr (sync clear of every stage),
//        lane_dat (word in), dly_dat (word delayed by DN cycles).
// DN must be at least 1; zero-delay paths are wired directly by the caller.
module delay_chain #(
    parameter int DW = 8,
    parameter int DN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] lane_dat,
    output logic [DW-1:0] dly_dat
);

    logic [DW-1:0] stage [DN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DN; s++) begin
                stage[s] <= '0;
            end
        end else if (clr) begin
            for (int s = 0; s < DN; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= lane_dat;
            for (int s = 1; s < DN; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign dly_dat = stage[DN-1];

endmodule

// File: rtl/lane_deskew.sv
// Removes the per-lane diagonal skew and emits one aligned, registered beat; flags broken diagonals.
// Latency: lane i is delayed LN-1-i stages plus the output register (lane 0: LN cycles, lane LN-1: 1).
// Backpressure: none; the consumer must take every out_vld cycle.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          sync clear of the delay stages, output flags and both counters
//   in_vld       per-lane valid, bit i = lane i
//   in_data      packed lanes, lane i = in_data[LANE(i)]
//   out_vld      registered aligned-beat valid
//   out_data     registered aligned vector (same packing), holds when no beat
//   err          one-cycle pulse for a misaligned (partial) beat
//   beat_cnt     aligned beats emitted, wraps
//   err_cnt      misaligned beats, saturates at 255
module lane_deskew
    import lane_deskew_pkg::*;
#(
    parameter int DW = 8,
    parameter int LN = 4,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [LN-1:0]    in_vld,
    input  logic [LN*DW-1:0] in_data,
    output logic             out_vld,
    output logic [LN*DW-1:0] out_data,
    output logic             err,
    output logic [CW-1:0]    beat_cnt,
    output logic [7:0]       err_cnt
);

    // Aligned (deskewed) valid and data, combinational from the delay stages.
    logic [LN-1:0]    a_vld;
    logic [LN*DW-1:0] a_data;

    beat_kind_t beat_kind;

    // ------------------------------------------------------------------
    // Per-lane deskew: each lane carries {valid, data} through its chain so
    // that valid and data stay paired stage by stage.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < LN; i++) begin : g_lane
        localparam int DN = deskew_depth(LN, i);

        if (DN == 0) begin : g_direct
            // Most-skewed lane already arrives last; no stages needed.
            assign a_vld[i]            = in_vld[i];
            assign a_data[`LANE(i)]    = in_data[`LANE(i)];
        end else begin : g_chain
            logic [DW:0] dly;

            delay_chain #(
                .DW (DW + 1),
                .DN (DN)
            ) u_dly (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .lane_dat ({in_vld[i], in_data[`LANE(i)]}),
                .dly_dat  (dly)
            );

            assign a_vld[i]         = dly[DW];
            assign a_data[`LANE(i)] = dly[DW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Classify the aligned valid vector.
    // ------------------------------------------------------------------
    always_comb begin
        beat_kind = BEAT_PART;
        if (&a_vld) begin
            beat_kind = BEAT_FULL;
        end else if (a_vld == '0) begin
            beat_kind = BEAT_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Output flags and counters. clr drops whatever beat is being evaluated
    // in the same cycle, so it sits ahead of the classification update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            err      <= 1'b0;
            beat_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr) begin
            out_vld  <= 1'b0;
            err      <= 1'b0;
            beat_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            out_vld <= (beat_kind == BEAT_FULL);
            err     <= (beat_kind == BEAT_PART);

            if (beat_kind == BEAT_FULL) begin
                beat_cnt <= beat_cnt + 1'b1;   // natural wrap at 2^CW
            end

            if ((beat_kind == BEAT_PART) && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // Output data only moves on a full beat; lanes with valid 0 never load it.
    // clr leaves the last aligned vector in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (!clr && (beat_kind == BEAT_FULL)) begin
            out_data <= a_data;
        end
    end

endmodule
